exe_pipe_ctrl: RTL and testbench
================================

Name: exe_pipe_ctrl

Overview:
- Pipeline control unit for the RV64 five-stage core.
- Owns the execute-stage operand-select inputs (rs1_src/rs2_src) and produces the stall, flush and redirect controls around the execute stage.
- Tracks in-flight destination registers in EX/ME/WB shadow slots to resolve data hazards.
- Sequences load-use bubbles, taken-branch/jump flushes and memory-busy freezes; keeps stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the stall_cycles and flush_count counters (saturating).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs1_addr  in  5  ID source register 1
- id_rs2_addr  in  5  ID source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- id_rd_addr  in  5  ID destination register
- id_rd_wen  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_b_flag  in  1  branch-taken flag from the execute stage
- ex_is_jump  in  1  EX instruction is JAL/JALR
- mem_busy  in  1  data memory not ready; freezes the pipeline
- rs1_src  out  2  EX rs1 select: 00 regfile, 01 me_alu_result, 10 wb_rd_data (11 unused)
- rs2_src  out  2  EX rs2 select, same encoding as rs1_src
- stall_if  out  1  hold PC
- stall_id  out  1  hold the IF/ID register
- stall_ex  out  1  hold the ID/EX and EX/ME registers
- flush_id  out  1  clear the IF/ID register
- flush_ex  out  1  insert a bubble into ID/EX
- pc_sel  out  1  1 = fetch from target_pc
- stall_cycles  out  CNT_W  cycles with stall_if asserted
- flush_count  out  CNT_W  number of redirects

Behaviour:
- Reset:
  - All slots invalid; FSM = RUN.
  - rs1_src = rs2_src = 00; all stall, flush and pc_sel outputs 0; counters 0.
- Shadow slots:
  - EX, ME and WB each hold {valid, rd, wen, load}.
  - When not frozen, every cycle: WB <= ME, ME <= EX, EX <= {id_valid & ~bubble & ~redirect, id_rd_addr, id_rd_wen, id_is_load}.
- Match(slot, rs): slot.valid & slot.wen & slot.rd != 0 & rs_used & slot.rd == rs. x0 is never forwarded.
- Forwarding:
  - rs*_src is registered and valid during the cycle the instruction sits in EX.
  - Next value = 01 if Match(EX slot), else 10 if Match(ME slot), else 00. EX has priority over ME.
  - A load in the ME slot yields 10, which is legal.
  - A WB-slot match needs no forward: the regfile is write-first.
- Load-use:
  - Condition: id_valid & Match(EX slot) where EX slot.load = 1, and no redirect.
  - Combinationally assert stall_if = stall_id = flush_ex = 1 for exactly one cycle; FSM RUN -> BUBBLE.
  - Next cycle the EX slot is invalid; the load is in ME, so the retried ID instruction gets 10. BUBBLE -> RUN unconditionally.
- Redirect:
  - Condition: EX slot valid & (ex_b_flag | ex_is_jump) & ~mem_busy.
  - Combinationally pc_sel = flush_id = flush_ex = 1; EX slot invalid next cycle; flush_count += 1.
  - Redirect overrides load-use: stall_if/stall_id = 0 that cycle and the FSM does not enter BUBBLE.
- Freeze:
  - mem_busy = 1 in any state: FSM -> FREEZE; stall_if = stall_id = stall_ex = 1; pc_sel = flush_id = flush_ex = 0.
  - Slots, rs*_src and the FSM return state are held.
  - A pending redirect or load-use is evaluated in the first cycle mem_busy = 0; the datapath holds ex_b_flag stable while frozen.
  - FREEZE -> saved state when mem_busy drops. A BUBBLE interrupted by a freeze completes after the freeze.
- Counters:
  - stall_cycles increments in every cycle with stall_if = 1.
  - Both counters saturate at all-ones; no wrap.
- Reset mid-operation: all slots, the FSM, outputs and counters return to their reset values on the next clock edge, regardless of state.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 back-to-back -> sub's EX cycle: rs1_src=01, rs2_src=00, no stall.
- add x5 ; nop ; or x7,x4,x5 -> or's EX cycle: rs2_src=10; three instrs with rd=x0 -> all rs*_src=00.
- ld x5 then add x6,x5,x5 -> one cycle stall_if=stall_id=flush_ex=1, next cycle add in EX with rs1_src=rs2_src=10, stall_cycles=1.
- beq in EX with ex_b_flag=1 while ID holds a load-use dependent -> pc_sel=flush_id=flush_ex=1, stall_if=0, flush_count=1, following EX slot invalid.
- mem_busy high 3 cycles with a taken branch in EX -> stall_if/id/ex=1 for 3 cycles, pc_sel=0 throughout, pc_sel=1 in the 4th cycle, stall_cycles=3.
- Assert rst during BUBBLE -> next cycle all outputs 0, counters 0, FSM RUN.

Source files
------------

// File: rtl/exe_pipe_ctrl.sv
// ============================================================================
// Module      : exe_pipe_ctrl
// Description : Execute-stage pipeline control. Selects forwarding sources,
//               sequences load-use bubbles, redirect flushes and memory-busy
//               freezes, and counts stalled cycles and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd_addr,
   input  logic             id_rd_wen,
   input  logic             id_is_load,
   input  logic             ex_b_flag,
   input  logic             ex_is_jump,
   input  logic             mem_busy,
   output logic [1:0]       rs1_src,
   output logic [1:0]       rs2_src,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             pc_sel,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [1:0] c_run    = 2'd0;
   localparam logic [1:0] c_bubble = 2'd1;
   localparam logic [1:0] c_freeze = 2'd2;

   localparam logic [1:0] c_src_rf = 2'b00;
   localparam logic [1:0] c_src_me = 2'b01;
   localparam logic [1:0] c_src_wb = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       load;
   } slot_t;

   slot_t            r_ex, r_me, r_wb;
   logic [1:0]       r_state, r_ret_state, w_next_state, w_eff_state;
   logic [1:0]       r_rs1_src, r_rs2_src, w_rs1_src, w_rs2_src;
   logic [CNT_W-1:0] r_stall_cycles, r_flush_count;
   logic             w_redirect, w_load_use;
   logic             w_ex_m1, w_ex_m2, w_me_m1, w_me_m2, w_wb_m1, w_wb_m2;

   function automatic logic f_match(input slot_t s, input logic [4:0] rs, input logic used);
      return s.valid && s.wen && (s.rd != 5'd0) && used && (s.rd == rs);
   endfunction

   // A WB-slot producer is already visible through the write-first regfile.
   function automatic logic [1:0] f_src(input logic ex_m, input logic me_m, input logic wb_m);
      if (ex_m)      return c_src_me;
      else if (me_m) return c_src_wb;
      else if (wb_m) return c_src_rf;
      else           return c_src_rf;
   endfunction

   assign w_ex_m1 = f_match(r_ex, id_rs1_addr, id_rs1_used);
   assign w_ex_m2 = f_match(r_ex, id_rs2_addr, id_rs2_used);
   assign w_me_m1 = f_match(r_me, id_rs1_addr, id_rs1_used);
   assign w_me_m2 = f_match(r_me, id_rs2_addr, id_rs2_used);
   assign w_wb_m1 = f_match(r_wb, id_rs1_addr, id_rs1_used);
   assign w_wb_m2 = f_match(r_wb, id_rs2_addr, id_rs2_used);

   assign w_rs1_src = f_src(w_ex_m1, w_me_m1, w_wb_m1);
   assign w_rs2_src = f_src(w_ex_m2, w_me_m2, w_wb_m2);

   // Both events wait out a freeze; redirect wins over load-use.
   assign w_redirect = r_ex.valid & (ex_b_flag | ex_is_jump) & ~mem_busy;
   assign w_load_use = id_valid & r_ex.load & (w_ex_m1 | w_ex_m2) & ~w_redirect & ~mem_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_run;
         r_ret_state <= c_run;
      end else begin
         r_state <= w_next_state;
         if (mem_busy && (r_state != c_freeze))
            r_ret_state <= r_state;
      end
   end

   always_comb begin
      w_eff_state  = (r_state == c_freeze) ? r_ret_state : r_state;
      w_next_state = c_run;
      if (mem_busy) begin
         w_next_state = c_freeze;
      end else begin
         case (w_eff_state)
            c_run:    w_next_state = w_load_use ? c_bubble : c_run;
            c_bubble: w_next_state = c_run;
            default:  w_next_state = c_run;
         endcase
      end
   end

   always_comb begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      pc_sel   = 1'b0;
      if (mem_busy) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         stall_ex = 1'b1;
      end else if (w_redirect) begin
         pc_sel   = 1'b1;
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (w_load_use) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex      <= '0;
         r_me      <= '0;
         r_wb      <= '0;
         r_rs1_src <= c_src_rf;
         r_rs2_src <= c_src_rf;
      end else if (!mem_busy) begin
         r_wb      <= r_me;
         r_me      <= r_ex;
         r_ex      <= '{valid: id_valid & ~w_load_use & ~w_redirect,
                        rd: id_rd_addr, wen: id_rd_wen, load: id_is_load};
         r_rs1_src <= w_rs1_src;
         r_rs2_src <= w_rs2_src;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (stall_if && (r_stall_cycles != {CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         if (w_redirect && (r_flush_count != {CNT_W{1'b1}}))
            r_flush_count <= r_flush_count + 1'b1;
      end
   end

   assign rs1_src      = r_rs1_src;
   assign rs2_src      = r_rs2_src;
   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_exe_pipe_ctrl.sv
// ============================================================================
// Module      : tb_exe_pipe_ctrl
// Description : Directed self-checking bench for exe_pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_is_load;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic        ex_b_flag, ex_is_jump, mem_busy;
   logic [1:0]  rs1_src, rs2_src;
   logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_sel;
   logic [31:0] stall_cycles, flush_count;

   int nvec;
   int nerr;

   exe_pipe_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
      .ex_b_flag(ex_b_flag), .ex_is_jump(ex_is_jump), .mem_busy(mem_busy),
      .rs1_src(rs1_src), .rs2_src(rs2_src),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .flush_id(flush_id), .flush_ex(flush_ex), .pc_sel(pc_sel),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic ld);
      id_valid = v; id_rs1_addr = r1; id_rs2_addr = r2; id_rs1_used = u1;
      id_rs2_used = u2; id_rd_addr = rd; id_rd_wen = wen; id_is_load = ld;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; idle(); ex_b_flag = 1'b0; ex_is_jump = 1'b0; mem_busy = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #3;
      nvec++; if ({rs1_src, rs2_src} !== 4'b0000) begin nerr++; $display("FAIL reset_src: got %b want 0000", {rs1_src, rs2_src}); end
      nvec++; if ({stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_sel} !== 6'b0) begin nerr++;
         $display("FAIL reset_ctrl: got %b want 000000", {stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_sel}); end
      nvec++; if ({stall_cycles, flush_count} !== 64'd0) begin nerr++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_count); end
      tick();
   endtask

   task automatic test_fwd_ex();
      do_reset();
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);           // add x5,x1,x2
      tick();
      set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0);           // sub x6,x5,x3
      #3;
      nvec++; if ({stall_if, flush_ex} !== 2'b00) begin nerr++; $display("FAIL fwd_ex_nostall: got %b want 00", {stall_if, flush_ex}); end
      tick();
      idle();
      #3;
      nvec++; if (rs1_src !== 2'b01) begin nerr++; $display("FAIL fwd_ex_rs1: got %b want 01", rs1_src); end
      nvec++; if (rs2_src !== 2'b00) begin nerr++; $display("FAIL fwd_ex_rs2: got %b want 00", rs2_src); end
      tick();
   endtask

   task automatic test_fwd_me_x0();
      do_reset();
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);           // add x5
      tick();
      set_id(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);           // nop
      tick();
      set_id(1, 5'd4, 5'd5, 1, 1, 5'd7, 1, 0);           // or x7,x4,x5
      tick();
      set_id(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0);           // writes and reads x0
      #3;
      nvec++; if ({rs1_src, rs2_src} !== 4'b0010) begin nerr++; $display("FAIL fwd_me: got %b want 0010", {rs1_src, rs2_src}); end
      for (int i = 0; i < 3; i++) begin
         tick();
         #3;
         nvec++; if ({rs1_src, rs2_src} !== 4'b0000) begin nerr++; $display("FAIL fwd_x0_%0d: got %b want 0000", i, {rs1_src, rs2_src}); end
      end
      idle();
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);           // ld x5
      tick();
      set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);           // add x6,x5,x5
      #3;
      nvec++; if ({stall_if, stall_id, flush_ex, stall_ex, pc_sel} !== 5'b11100) begin nerr++;
         $display("FAIL lu_stall: got %b want 11100", {stall_if, stall_id, flush_ex, stall_ex, pc_sel}); end
      tick();
      #3;
      nvec++; if ({stall_if, flush_ex} !== 2'b00) begin nerr++; $display("FAIL lu_bubble_once: got %b want 00", {stall_if, flush_ex}); end
      nvec++; if (stall_cycles !== 32'd1) begin nerr++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cycles); end
      tick();
      idle();
      #3;
      nvec++; if ({rs1_src, rs2_src} !== 4'b1010) begin nerr++; $display("FAIL lu_fwd: got %b want 1010", {rs1_src, rs2_src}); end
      tick();
   endtask

   task automatic test_redirect();
      do_reset();
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);           // load-type producer in EX
      tick();
      set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
      ex_b_flag = 1'b1;
      #3;
      nvec++; if ({pc_sel, flush_id, flush_ex, stall_if, stall_id} !== 5'b11100) begin nerr++;
         $display("FAIL redir_ctrl: got %b want 11100", {pc_sel, flush_id, flush_ex, stall_if, stall_id}); end
      tick();
      #3;
      nvec++; if (flush_count !== 32'd1) begin nerr++; $display("FAIL redir_cnt: got %0d want 1", flush_count); end
      nvec++; if ({pc_sel, stall_if} !== 2'b00) begin nerr++; $display("FAIL redir_ex_invalid: got %b want 00", {pc_sel, stall_if}); end
      nvec++; if (stall_cycles !== 32'd0) begin nerr++; $display("FAIL redir_nostall_cnt: got %0d want 0", stall_cycles); end
      ex_b_flag = 1'b0;
      set_id(1, 5'd0, 5'd0, 0, 0, 5'd1, 1, 0);           // jal x1
      tick();
      idle();
      ex_is_jump = 1'b1;
      #3;
      nvec++; if (pc_sel !== 1'b1) begin nerr++; $display("FAIL jump_pcsel: got %b want 1", pc_sel); end
      tick();
      ex_is_jump = 1'b0;
      #3;
      nvec++; if (flush_count !== 32'd2) begin nerr++; $display("FAIL jump_cnt: got %0d want 2", flush_count); end
      tick();
   endtask

   task automatic test_freeze();
      do_reset();
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0);           // beq x1,x2
      tick();
      idle();
      ex_b_flag = 1'b1;
      mem_busy  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         nvec++; if ({stall_if, stall_id, stall_ex, pc_sel, flush_id, flush_ex} !== 6'b111000) begin nerr++;
            $display("FAIL frz_%0d: got %b want 111000", i, {stall_if, stall_id, stall_ex, pc_sel, flush_id, flush_ex}); end
         tick();
      end
      mem_busy = 1'b0;
      #3;
      nvec++; if ({pc_sel, flush_ex, stall_if, stall_ex} !== 4'b1100) begin nerr++;
         $display("FAIL frz_redir: got %b want 1100", {pc_sel, flush_ex, stall_if, stall_ex}); end
      nvec++; if (stall_cycles !== 32'd3) begin nerr++; $display("FAIL frz_stall_cnt: got %0d want 3", stall_cycles); end
      tick();
      ex_b_flag = 1'b0;
      #3;
      nvec++; if (flush_count !== 32'd1) begin nerr++; $display("FAIL frz_flush_cnt: got %0d want 1", flush_count); end
      tick();
   endtask

   task automatic test_freeze_bubble();
      do_reset();
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);           // ld x5
      tick();
      set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);           // add x6,x5,x5
      #3;
      nvec++; if (stall_if !== 1'b1) begin nerr++; $display("FAIL fb_lu: got %b want 1", stall_if); end
      tick();
      mem_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #3;
         nvec++; if (stall_ex !== 1'b1) begin nerr++; $display("FAIL fb_frz_%0d: got %b want 1", i, stall_ex); end
         tick();
      end
      mem_busy = 1'b0;
      #3;
      nvec++; if ({stall_if, flush_ex} !== 2'b00) begin nerr++; $display("FAIL fb_exit: got %b want 00", {stall_if, flush_ex}); end
      nvec++; if (stall_cycles !== 32'd3) begin nerr++; $display("FAIL fb_stall_cnt: got %0d want 3", stall_cycles); end
      tick();
      idle();
      #3;
      nvec++; if ({rs1_src, rs2_src} !== 4'b1010) begin nerr++; $display("FAIL fb_fwd: got %b want 1010", {rs1_src, rs2_src}); end
      tick();
   endtask

   task automatic test_reset_mid_bubble();
      do_reset();
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
      tick();
      set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
      tick();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      #3;
      nvec++; if ({rs1_src, rs2_src, stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_sel} !== 10'b0) begin nerr++;
         $display("FAIL rstmid_out: got %b want 0", {rs1_src, rs2_src, stall_if, stall_id, stall_ex, flush_id, flush_ex, pc_sel}); end
      nvec++; if ({stall_cycles, flush_count} !== 64'd0) begin nerr++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", stall_cycles, flush_count); end
      set_id(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
      tick();
      idle();
      #3;
      nvec++; if ({rs1_src, rs2_src} !== 4'b0000) begin nerr++; $display("FAIL rstmid_slots: got %b want 0000", {rs1_src, rs2_src}); end
      tick();
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      rst = 1'b1; idle(); ex_b_flag = 1'b0; ex_is_jump = 1'b0; mem_busy = 1'b0;
      test_reset();
      test_fwd_ex();
      test_fwd_me_x0();
      test_load_use();
      test_redirect();
      test_freeze();
      test_freeze_bubble();
      test_reset_mid_bubble();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
